// File: rtl/pipelined_barrel_shifter.sv
// Streaming multi-mode barrel shifter: one registered stage per shift-amount bit, one beat per clock.
// Latency SHAMT_W cycles; a stalled output freezes the whole pipeline and drops in_ready.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam logic [2:0] MODE_SRL = 3'b000;
  localparam logic [2:0] MODE_SRA = 3'b001;
  localparam logic [2:0] MODE_SLL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  logic               advance;

  logic               vld_q   [SHAMT_W];
  logic [WIDTH-1:0]   dat_q   [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [2:0]         mode_q  [SHAMT_W];
  logic               sign_q  [SHAMT_W];

  logic               prv_vld   [SHAMT_W];
  logic [WIDTH-1:0]   prv_dat   [SHAMT_W];
  logic [SHAMT_W-1:0] prv_shamt [SHAMT_W];
  logic [2:0]         prv_mode  [SHAMT_W];
  logic               prv_sign  [SHAMT_W];
  logic [WIDTH-1:0]   nxt_dat   [SHAMT_W];

  // SRA fills with the operand's original sign, which rides along as sign_q.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       m,
                                                   input logic             sgn,
                                                   input int               s);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    fill = ~({WIDTH{1'b1}} >> s);
    case (m)
      MODE_SRL: r = d >> s;
      MODE_SRA: r = (d >> s) | (sgn ? fill : '0);
      MODE_SLL: r = d << s;
      MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
      MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
      default:  r = d;
    endcase
    return r;
  endfunction

  assign out_valid = vld_q[SHAMT_W-1];
  assign out_data  = dat_q[SHAMT_W-1];
  assign out_zero  = (out_data == '0);
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    prv_vld[0]   = in_valid;
    prv_dat[0]   = in_data;
    prv_shamt[0] = in_shamt;
    prv_mode[0]  = in_mode;
    prv_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      prv_vld[k]   = vld_q[k-1];
      prv_dat[k]   = dat_q[k-1];
      prv_shamt[k] = shamt_q[k-1];
      prv_mode[k]  = mode_q[k-1];
      prv_sign[k]  = sign_q[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++) begin
      nxt_dat[k] = prv_shamt[k][k] ? shift_stage(prv_dat[k], prv_mode[k], prv_sign[k], 1 << k)
                                   : prv_dat[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        vld_q[k]   <= 1'b0;
        dat_q[k]   <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        sign_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        vld_q[k]   <= prv_vld[k];
        dat_q[k]   <= nxt_dat[k];
        shamt_q[k] <= prv_shamt[k];
        mode_q[k]  <= prv_mode[k];
        sign_q[k]  <= prv_sign[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed table, back-pressure, mid-stream reset,
// randomized traffic against a whole-shift reference model, and a 32-bit instance.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_shamt;
  logic [2:0]  in_mode;

  logic        v32, rdy32, ov32, ordy32, oz32;
  logic [31:0] d32, od32;
  logic [4:0]  sh32;
  logic [2:0]  m32;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_shamt(sh32), .in_mode(m32),
    .out_valid(ov32), .out_ready(ordy32),
    .out_data(od32), .out_zero(oz32)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-shift reference: operand of width w shifted by sh in one arithmetic step.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] m,
                                        input int sh, input int w);
    logic [63:0]        mask, x, r;
    logic signed [63:0] sx;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    case (m)
      3'd0: r = x >> sh;
      3'd1: begin sx = $signed(x << (64 - w)); r = sx >>> (64 - w + sh); end
      3'd2: r = x << sh;
      3'd3: r = (x >> sh) | (x << (w - sh));
      3'd4: r = (x << sh) | (x >> (w - sh));
      default: r = x;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  typedef struct {
    logic [15:0] exp;
    int          cyc;
    bit          lat;
  } sb_t;
  sb_t sb[$];

  logic [15:0] drv_exp;
  bit          drv_lat;
  bit          stalled_prev = 0;
  logic [15:0] prev_dat;

  always @(posedge clk) cyc++;

  // Scoreboard: expectations queued at acceptance, compared when consumed.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb.delete();
      stalled_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_or_stale_beat", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e.exp});
          check("out_zero", {31'd0, out_zero}, {31'd0, (e.exp == 16'd0)});
          if (e.lat) check("latency", cyc - e.cyc, 32'd4);
        end
      end
      if (stalled_prev && out_valid) check("stall_hold", {16'd0, out_data}, {16'd0, prev_dat});
      if (out_valid && !out_ready) check("in_ready_stall", {31'd0, in_ready}, 32'd0);
      stalled_prev = out_valid && !out_ready;
      prev_dat     = out_data;
      if (in_valid && in_ready) begin
        e.exp = drv_exp; e.cyc = cyc; e.lat = drv_lat;
        sb.push_back(e);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [2:0] m, input logic [3:0] sh,
                      input logic [15:0] e, input bit lat);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_shamt = sh;
    drv_exp = e; drv_lat = lat;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [15:0] d;
    logic [2:0]  m;
    logic [3:0]  sh;
    logic [31:0] r;
    d = 16'($urandom); m = 3'($urandom_range(0, 7)); sh = 4'($urandom_range(0, 15));
    r = model({16'd0, d}, m, int'(sh), 16);
    send(d, m, sh, r[15:0], lat);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send32(input logic [31:0] d, input logic [2:0] m, input logic [4:0] sh,
                        input logic [31:0] e);
    int lat;
    v32 = 1'b1; d32 = d; m32 = m; sh32 = sh;
    @(negedge clk);
    check("in_ready32", {31'd0, rdy32}, 32'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      lat++;
      if (ov32) break;
    end
    check("out_data32", od32, e);
    check("latency32", lat, 32'd5);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [2:0]  m;
    logic [3:0]  sh;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[9];

  bit rnd_done;

  initial begin
    tbl[0] = '{16'hAAAA, 3'b000, 4'd1,  16'h5555};
    tbl[1] = '{16'h8000, 3'b001, 4'd4,  16'hF800};
    tbl[2] = '{16'h0001, 3'b010, 4'd15, 16'h8000};
    tbl[3] = '{16'h1234, 3'b011, 4'd4,  16'h4123};
    tbl[4] = '{16'h8001, 3'b100, 4'd1,  16'h0003};
    tbl[5] = '{16'h00F0, 3'b111, 4'd7,  16'h00F0};
    tbl[6] = '{16'hFFFF, 3'b000, 4'd15, 16'h0001};
    tbl[7] = '{16'h0001, 3'b000, 4'd1,  16'h0000};
    tbl[8] = '{16'h8000, 3'b001, 4'd15, 16'hFFFF};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    out_ready = 1'b1; drv_exp = '0; drv_lat = 0;
    v32 = 1'b0; d32 = '0; sh32 = '0; m32 = '0; ordy32 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors, back to back, latency checked on each.
    for (int i = 0; i < 9; i++) send(tbl[i].d, tbl[i].m, tbl[i].sh, tbl[i].exp, 1);
    drain();

    // shamt = 0 returns the operand for every mode.
    for (int m = 0; m < 8; m++) send(16'hC3A5, 3'(m), 4'd0, 16'hC3A5, 1);
    drain();

    // Back-pressure: 6 beats with a 5-cycle output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) send_rand(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_data", {16'd0, out_data}, 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure and input gaps.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rand(0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // 32-bit instance.
    send32(32'h8000_0000, 3'b001, 5'd31, 32'hFFFF_FFFF);
    send32(32'h0000_0001, 3'b011, 5'd1,  32'h8000_0000);
    send32(32'h1234_5678, 3'b100, 5'd8,  model(32'h1234_5678, 3'b100, 8, 32));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined multi-mode barrel shifter. Supports logical/arithmetic right shift, logical left shift, and left/right rotate on a WIDTH-bit operand. Uses one registered log2 stage per shift-amount bit and a valid/ready handshake on both sides. Sits in the datapath as a streaming shift unit with one result per clock and back-pressure support.

Parameters:
- WIDTH, 16: operand width; power of two, minimum 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width and pipeline depth. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  shifter can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  3  000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL, 101-111 pass-through.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  high when out_data == 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All stage valid bits, data, shamt and mode registers clear to 0.
  - out_valid=0, out_data=0, out_zero=1.
  - In-flight beats are discarded; a reset mid-operation flushes the whole pipeline.
- Pipeline structure:
  - SHAMT_W register stages. Stage k (k=0..SHAMT_W-1) shifts by 2^k when shamt bit k is set, otherwise it passes data unchanged.
  - Shamt and mode travel with the data through every stage.
  - out_* are driven directly from the last stage's registers.
- Stall logic:
  - advance = !out_valid || out_ready.
  - When advance=1, every stage loads from its predecessor, and stage 0 loads in_* with valid = in_valid.
  - When advance=0, all stages hold their contents.
  - in_ready = advance (combinational from out_valid/out_ready only, not from in_valid).
  - Handshakes: input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.
- Latency and throughput:
  - With out_ready held high, a beat accepted at edge N appears with out_valid=1 after edge N+SHAMT_W-1, i.e. SHAMT_W cycles of latency (4 for WIDTH=16).
  - Throughput is one beat per cycle.
  - Bubbles are not collapsed: an empty stage still needs advance to move.
- Mode semantics per stage, shift s=2^k:
  - SRL: zero-fill from the MSB side.
  - SRA: fill with the operand's original MSB (sign bit), carried through the pipeline.
  - SLL: zero-fill from the LSB side.
  - ROR/ROL: bits wrap around modulo WIDTH.
  - Pass-through: data unchanged regardless of shamt.
- Boundary conditions:
  - shamt=0 returns in_data for every mode.
  - shamt=WIDTH-1 is the maximum; no saturation handling is needed because of the port width.
  - SRA of a negative value by WIDTH-1 yields all ones.
- Invariants:
  - While out_valid && !out_ready, out_data and out_zero stay stable.
  - Beats are never dropped or duplicated.
- out_zero is computed from the registered last-stage data and is valid only when out_valid=1.

Test Plan:
1. Reset, then out_ready=1 with beats 0xAAAA/SRL/1, 0x8000/SRA/4, 0x0001/SLL/15 on consecutive cycles -> outputs 0x5555, 0xF800, 0x8000 on three consecutive cycles, the first appearing 4 cycles after acceptance.
2. 0x1234/ROR/4, then 0x8001/ROL/1, then 0x00F0/mode 111/7 -> outputs 0x4123, 0x0003, 0x00F0.
3. 0xFFFF/SRL/15 -> 0x0001 with out_zero=0; 0x0001/SRL/1 -> 0x0000 with out_zero=1; 0x8000/SRA/15 -> 0xFFFF.
4. Back-pressure: stream 6 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once out_valid=1, out_data is held constant, and all 6 results emerge in order with no loss or duplication.
5. Reset mid-stream: 3 beats in flight, assert rst_n=0 for 1 cycle -> next cycle out_valid=0, out_data=0, and no stale beat ever appears afterwards.
6. Re-elaborate with WIDTH=32: 0x80000000/SRA/31 -> 0xFFFFFFFF; 0x00000001/ROR/1 -> 0x80000000; latency is 5 cycles.
